priority_clock_source_controller: RTL
=====================================

# priority_clock_source_controller

Single-clock controller that decides which of CHANNELS candidate clocks a downstream glitch-free clock multiplexer should forward. Each candidate's activity arrives as a toggle signal already synchronized into the `clock` domain. The block qualifies each channel as alive or dead using timeout and recovery hysteresis, then selects the highest-priority alive and enabled channel. It drives the multiplexer through a request/done handshake and generalises the two-clock primary/fallback scheme to N prioritised sources.

## Interface
- CHANNELS, 4: number of candidate clocks; index 0 has the highest priority; minimum 2.
- TIMEOUT, 16: `clock` cycles without a toggle edge after which a channel is declared dead; minimum 2.
- RECOVERY, 4: consecutive toggle edges, each within TIMEOUT, needed to promote a dead channel to alive; minimum 1.
- SELECT_WIDTH, $clog2(CHANNELS): width of `select`.

- clock  in  1  single clock of the block.
- reset  in  1  synchronous, active-high reset.
- activity_toggle  in  CHANNELS  per-channel toggle, pre-synchronized into `clock`; each transition counts as one edge.
- enable_mask  in  CHANNELS  1 = channel eligible for selection; does not affect health tracking.
- switch_done  in  1  multiplexer acknowledges that it has completed the switch to `select`.
- select  out  SELECT_WIDTH  channel index the multiplexer must forward.
- switch_request  out  1  high from a change of `select` until `switch_done`.
- channel_alive  out  CHANNELS  per-channel health state.
- none_alive  out  1  no channel is both alive and enabled.

## Operation
- Edge detect: edge[i] = activity_toggle[i] XOR the registered previous value. The previous value is reset to 0.
- Per-channel health FSM, states DEAD, PROBATION and ALIVE, with a timeout counter and a recovery counter:
  - Timeout counter clears on an edge. Otherwise it increments and saturates at TIMEOUT.
  - DEAD: an edge moves to PROBATION with recovery count 1. If RECOVERY=1, the edge moves straight to ALIVE.
  - PROBATION: each edge increments the recovery count; reaching RECOVERY moves to ALIVE. Counter reaching TIMEOUT moves to DEAD and clears the recovery count.
  - ALIVE: counter reaching TIMEOUT moves to DEAD.
  - channel_alive[i] = (state == ALIVE).
- Target = lowest index with channel_alive & enable_mask set.
- Selector FSM, states STABLE and SWITCHING:
  - STABLE, target valid and target != select: load select = target, assert switch_request, go to SWITCHING.
  - STABLE, no valid target: hold select; switch_request stays low.
  - SWITCHING: hold select and switch_request; ignore target changes; on switch_done, deassert switch_request and return to STABLE.
- switch_done while STABLE is ignored.
- The selected channel dying while SWITCHING is not aborted; it is re-evaluated on return to STABLE.

## Timing
- Reset values: select=0, switch_request=0, channel_alive=0, none_alive=1, all channels DEAD, all counters 0, selector STABLE.
- Edge at cycle t updates the health state at t+1. channel_alive and none_alive are registered and valid at t+1.
- Selector evaluates registered channel_alive: select and switch_request change at t+2 after the qualifying edge.
- Dead detection: the last edge at cycle t makes the channel DEAD at t+TIMEOUT+1.
- switch_done high at cycle t: switch_request low at t+1. A new request is possible at t+2 at the earliest.
- Reset asserted mid-switch: everything returns to reset values on the next edge; no handshake completion is required.
- Simultaneous edge and timeout in the same cycle: the edge wins and the counter clears.

## Structure
- Package priority_clock_source_controller_pkg: health state encoding (DEAD, PROBATION, ALIVE) and selector state encoding (STABLE, SWITCHING).
- Sub-module channel_activity_monitor: edge detect, timeout counter, recovery counter and health FSM for one channel. It is instantiated CHANNELS times in a generate loop.
- Top level contains the priority encoder, the selector FSM and the output registers.

## Test plan
- Reset, then toggle channel 2 every 4 cycles with defaults. After 4 edges, channel_alive=4'b0100. select=2 and switch_request=1 appear 2 cycles after the promotion; assert switch_done and switch_request falls the next cycle.
- Channels 1 and 3 alive with select=3; bring channel 0 alive. Expect select=0 and a handshake; no change occurs while SWITCHING even if channel 1 dies.
- Stop toggling selected channel 0 with channel 1 alive. Channel 0 goes DEAD 17 cycles after its last edge, then select=1 follows 1 cycle later.
- Channel 0 in PROBATION with 3 edges, then a gap of 16 cycles: it returns to DEAD with no alive bit and no select change. A following single edge restarts the recovery count at 1.
- Clear enable_mask[0] while channel 0 is alive and selected with channel 2 alive: select=2. Kill all channels: none_alive=1 and select holds 2.
- Assert reset while switch_request=1: next cycle select=0, switch_request=0, channel_alive=0 and none_alive=1.

Source files
------------

// File: rtl/priority_clock_source_controller_pkg.sv
// Shared encodings for the priority clock source controller.
// Health states per channel and selector handshake states.
package priority_clock_source_controller_pkg;

    typedef enum logic [1:0] {
        HEALTH_DEAD      = 2'd0,
        HEALTH_PROBATION = 2'd1,
        HEALTH_ALIVE     = 2'd2
    } health_state_t;

    typedef enum logic {
        SEL_STABLE    = 1'b0,
        SEL_SWITCHING = 1'b1
    } selector_state_t;

endpackage

// File: rtl/channel_activity_monitor.sv
// Health tracker for one candidate clock: edge detect, timeout and
// recovery hysteresis driving a DEAD/PROBATION/ALIVE state machine.
module channel_activity_monitor
    import priority_clock_source_controller_pkg::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int RECOVERY = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic activity_toggle,
    output logic alive,
    output logic alive_next
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RECOVERY + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT);
    localparam logic [RW-1:0] RECOVERY_MAX = RW'(RECOVERY);

    logic          toggle_prev;
    logic          activity_edge;
    logic          expired;
    logic [TW-1:0] timeout_count;
    logic [TW-1:0] timeout_next;
    logic [RW-1:0] recovery_count;
    logic [RW-1:0] recovery_next;
    logic [RW-1:0] recovery_inc;
    health_state_t state;
    health_state_t state_next;

    assign activity_edge = activity_toggle ^ toggle_prev;
    assign recovery_inc  = recovery_count + RW'(1);

    // An edge clears the counter, so it always beats a same-cycle timeout.
    always_comb begin
        timeout_next = timeout_count;
        if (activity_edge) begin
            timeout_next = '0;
        end else if (timeout_count != TIMEOUT_MAX) begin
            timeout_next = timeout_count + TW'(1);
        end
    end

    assign expired = (timeout_next == TIMEOUT_MAX);

    always_comb begin
        state_next    = state;
        recovery_next = recovery_count;
        unique case (state)
            HEALTH_DEAD: begin
                if (activity_edge) begin
                    recovery_next = RW'(1);
                    state_next    = (RECOVERY == 1) ? HEALTH_ALIVE
                                                    : HEALTH_PROBATION;
                end
            end
            HEALTH_PROBATION: begin
                if (activity_edge) begin
                    recovery_next = recovery_inc;
                    if (recovery_inc >= RECOVERY_MAX) begin
                        state_next = HEALTH_ALIVE;
                    end
                end else if (expired) begin
                    recovery_next = '0;
                    state_next    = HEALTH_DEAD;
                end
            end
            HEALTH_ALIVE: begin
                if (expired) begin
                    recovery_next = '0;
                    state_next    = HEALTH_DEAD;
                end
            end
            default: begin
                recovery_next = '0;
                state_next    = HEALTH_DEAD;
            end
        endcase
    end

    assign alive_next = (state_next == HEALTH_ALIVE);

    always_ff @(posedge clock) begin
        if (reset) begin
            toggle_prev    <= 1'b0;
            timeout_count  <= '0;
            recovery_count <= '0;
            state          <= HEALTH_DEAD;
            alive          <= 1'b0;
        end else begin
            toggle_prev    <= activity_toggle;
            timeout_count  <= timeout_next;
            recovery_count <= recovery_next;
            state          <= state_next;
            alive          <= alive_next;
        end
    end

endmodule

// File: rtl/priority_clock_source_controller.sv
// Picks the highest-priority alive and enabled clock source and drives
// the downstream glitch-free mux through a request/done handshake.
module priority_clock_source_controller
    import priority_clock_source_controller_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TIMEOUT      = 16,
    parameter int RECOVERY     = 4,
    parameter int SELECT_WIDTH = $clog2(CHANNELS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     activity_toggle,
    input  logic [CHANNELS-1:0]     enable_mask,
    input  logic                    switch_done,
    output logic [SELECT_WIDTH-1:0] select,
    output logic                    switch_request,
    output logic [CHANNELS-1:0]     channel_alive,
    output logic                    none_alive
);

    logic [CHANNELS-1:0]     alive_next;
    logic [CHANNELS-1:0]     eligible;
    logic [SELECT_WIDTH-1:0] target;
    logic                    target_valid;
    selector_state_t         sel_state;

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_channel
        channel_activity_monitor #(
            .TIMEOUT  (TIMEOUT),
            .RECOVERY (RECOVERY)
        ) u_monitor (
            .clock           (clock),
            .reset           (reset),
            .activity_toggle (activity_toggle[g]),
            .alive           (channel_alive[g]),
            .alive_next      (alive_next[g])
        );
    end

    assign eligible = channel_alive & enable_mask;

    // Descending scan so the lowest eligible index wins.
    always_comb begin
        target_valid = 1'b0;
        target       = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                target_valid = 1'b1;
                target       = SELECT_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            select         <= '0;
            switch_request <= 1'b0;
            none_alive     <= 1'b1;
            sel_state      <= SEL_STABLE;
        end else begin
            none_alive <= ~|(alive_next & enable_mask);
            unique case (sel_state)
                SEL_STABLE: begin
                    if (target_valid && (target != select)) begin
                        select         <= target;
                        switch_request <= 1'b1;
                        sel_state      <= SEL_SWITCHING;
                    end
                end
                SEL_SWITCHING: begin
                    // Target changes wait until the mux has finished.
                    if (switch_done) begin
                        switch_request <= 1'b0;
                        sel_state      <= SEL_STABLE;
                    end
                end
                default: begin
                    switch_request <= 1'b0;
                    sel_state      <= SEL_STABLE;
                end
            endcase
        end
    end

endmodule
